address_composer: RTL
=====================

ADDRESS_COMPOSER -- requirements
Module: address_composer

Interface
REQ-001 SHALL have parameters: addressSize, default 32, full address width; tagBits, default 12, tag field width; indexBits, default 14, set index width; byteSelectBits, default 6, line offset width; beatBytesLog2, default 3, log2 of bytes per memory beat.
REQ-002 SHALL have these ports, clock and reset first:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
reqValid  input  1  writeback/fill request present.
reqReady  output  1  block can accept a request.
reqTag  input  tagBits  line tag.
reqIndex  input  indexBits  line set index.
reqByteSelect  input  byteSelectBits  requested byte within the line.
addrValid  output  1  address beat valid.
addrReady  input  1  memory side accepts the beat.
address  output  addressSize  composed beat address.
addrLast  output  1  final beat of the burst.
busy  output  1  burst in progress.

Function
REQ-003 SHALL compose address = {tag, index, beatNumber, beatBytesLog2 zero bits}, the exact inverse of the tag/index/byte-select split used by the cache.
REQ-004 SHALL issue beats = 2^(byteSelectBits - beatBytesLog2) per request; defaults give 8 beats, stride 8 bytes.
REQ-005 SHALL implement FSM IDLE, BURST; IDLE: reqReady=1, addrValid=0; reqValid in IDLE captures tag, index and start beat, next state BURST.
REQ-006 SHALL drive the first beat's addrValid=1 in the cycle after request acceptance (latency 1).
REQ-007 BURST: reqReady=0, addrValid=1, busy=1; a new reqValid SHALL be ignored, not queued.
REQ-008 SHALL advance the beat only on addrValid && addrReady; beat number increments modulo beat count.
REQ-009 SHALL hold address and addrLast stable while addrValid && !addrReady.
REQ-010 SHALL assert addrLast on the final beat of the burst only; acceptance of that beat SHALL return to IDLE, with reqReady=1 in the next cycle.
REQ-011 SHALL count accepted beats in a counter separate from the beat number, so termination is independent of the start beat.
REQ-012 SHALL reject, at elaboration, parameters where tagBits + indexBits + byteSelectBits != addressSize or beatBytesLog2 > byteSelectBits.

Reset
REQ-013 On rst SHALL go to IDLE; reqReady=1, addrValid=0, addrLast=0, busy=0, address=0, counters=0.
REQ-014 rst mid-burst SHALL abandon the burst; no further beats are issued, and addrValid=0 in the cycle after rst is sampled.
REQ-015 rst SHALL take priority over a simultaneous reqValid or addrReady.

Configuration
REQ-016 Macro ADDRESS_COMPOSER_WRAP_BURST_EN defined: the start beat SHALL be reqByteSelect[byteSelectBits-1:beatBytesLog2] (critical word first), with wrap to beat 0 after the highest beat.
REQ-017 Macro undefined: the start beat SHALL always be 0, reqByteSelect SHALL be ignored, and the burst is linear.

Structure
REQ-018 Package cache_addr_pkg SHALL hold the default field-width constants shared with the address dissector and the FSM state enum typedef.
REQ-019 Sub-module burst_beat_counter SHALL hold the loadable beat-number/beat-count pair and generate the last-beat flag.

Verification
REQ-020 Tag 0xABC, index 0x1234, byteSelect 0x1A, macro off, addrReady=1 -> 8 beats 0xABC48D00..0xABC48D38 on consecutive cycles, addrLast on 0xABC48D38.
REQ-021 Same request, macro on -> beats 0xABC48D18, 20, 28, 30, 38, 00, 08, 10, with addrLast on 0xABC48D10.
REQ-022 addrReady low for 3 cycles on beat 2 -> address 0xABC48D10 held for 4 cycles, total 8 beats, no skipped or duplicated beat.
REQ-023 reqValid pulsed during BURST with tag 0x111 -> ignored; the current burst completes unchanged, and reqReady=1 only after the last beat.
REQ-024 rst asserted on beat 4 -> addrValid=0 next cycle, reqReady=1, busy=0; a new request then starts cleanly at its first beat.
REQ-025 Back-to-back requests: a second reqValid held from the cycle of the last beat -> accepted in the cycle after the last beat, first beat one cycle later.

Source files
------------

// File: rtl/cache_addr_pkg.sv
// Shared cache address field widths and the burst FSM state type used by
// address_composer and the matching address dissector.
package cache_addr_pkg;

  localparam int ADDRESS_SIZE     = 32;
  localparam int TAG_BITS         = 12;
  localparam int INDEX_BITS       = 14;
  localparam int BYTE_SELECT_BITS = 6;
  localparam int BEAT_BYTES_LOG2  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  // Width of the beat-number field inside the byte-select field.
  function automatic int beat_field_bits(input int byte_select_bits, input int beat_bytes_log2);
    return byte_select_bits - beat_bytes_log2;
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Loadable beat number (wraps modulo beat count) plus an independent count of
// accepted beats that alone decides when the burst ends.
module burst_beat_counter #(
  parameter int BeatBits = 3,
  localparam int BeatW = (BeatBits > 0) ? BeatBits : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [BeatW-1:0] start_beat_i,
  input  logic             advance_i,
  output logic [BeatW-1:0] beat_o,
  output logic             last_o
);

  logic [BeatW-1:0] beat_q, beat_d;
  logic [BeatW-1:0] count_q, count_d;

  always_comb begin
    beat_d  = beat_q;
    count_d = count_q;
    if (load_i) begin
      beat_d  = start_beat_i;
      count_d = '0;
    end else if (advance_i) begin
      beat_d  = beat_q + BeatW'(1);
      count_d = count_q + BeatW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      beat_q  <= beat_d;
      count_q <= count_d;
    end
  end

  // A single-beat line has no beat field: every beat is both first and last.
  generate
    if (BeatBits > 0) begin : g_multi_beat
      assign beat_o = beat_q;
      assign last_o = &count_q;
    end else begin : g_single_beat
      assign beat_o = '0;
      assign last_o = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/address_composer.sv
// Rebuilds a line's beat addresses {tag, index, beat, 0..0} for writeback/fill bursts.
// Define ADDRESS_COMPOSER_WRAP_BURST_EN for critical-word-first wrapping bursts.
module address_composer
  import cache_addr_pkg::*;
#(
  parameter int addressSize    = ADDRESS_SIZE,
  parameter int tagBits        = TAG_BITS,
  parameter int indexBits      = INDEX_BITS,
  parameter int byteSelectBits = BYTE_SELECT_BITS,
  parameter int beatBytesLog2  = BEAT_BYTES_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reqValid,
  output logic                      reqReady,
  input  logic [tagBits-1:0]        reqTag,
  input  logic [indexBits-1:0]      reqIndex,
  input  logic [byteSelectBits-1:0] reqByteSelect,
  output logic                      addrValid,
  input  logic                      addrReady,
  output logic [addressSize-1:0]    address,
  output logic                      addrLast,
  output logic                      busy
);

  localparam int BeatBits = beat_field_bits(byteSelectBits, beatBytesLog2);
  localparam int BeatW    = (BeatBits > 0) ? BeatBits : 1;

  generate
    if ((tagBits + indexBits + byteSelectBits != addressSize) ||
        (beatBytesLog2 > byteSelectBits)) begin : g_bad_params
      $error("address_composer: field widths do not tile the address");
    end
  endgenerate

  burst_state_e         state_q, state_d;
  logic [tagBits-1:0]   tag_q, tag_d;
  logic [indexBits-1:0] index_q, index_d;
  logic [BeatW-1:0]     start_beat;
  logic [BeatW-1:0]     beat;
  logic                 last_beat;
  logic                 load;
  logic                 advance;
  logic                 unused_byte_select;

  // Only the beat field of the byte select matters, and only for wrapping bursts.
  assign unused_byte_select = ^reqByteSelect;

`ifdef ADDRESS_COMPOSER_WRAP_BURST_EN
  generate
    if (BeatBits > 0) begin : g_wrap_start
      assign start_beat = reqByteSelect[byteSelectBits-1:beatBytesLog2];
    end else begin : g_wrap_single
      assign start_beat = '0;
    end
  endgenerate
`else
  assign start_beat = '0;
`endif

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          load    = 1'b1;
          tag_d   = reqTag;
          index_d = reqIndex;
          state_d = BURST;
        end
      end
      BURST: begin
        // Requests arriving here are dropped; the requester must retry.
        if (addrReady) begin
          advance = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
    end
  end

  burst_beat_counter #(
    .BeatBits(BeatBits)
  ) u_beat_counter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .start_beat_i(start_beat),
    .advance_i   (advance),
    .beat_o      (beat),
    .last_o      (last_beat)
  );

  assign reqReady  = (state_q == IDLE);
  assign addrValid = (state_q == BURST);
  assign busy      = (state_q == BURST);
  assign addrLast  = (state_q == BURST) && last_beat;
  assign address   = (addressSize'(tag_q) << (indexBits + byteSelectBits)) |
                     (addressSize'(index_q) << byteSelectBits) |
                     (addressSize'(beat) << beatBytesLog2);

endmodule
